// File: rtl/encout_pkg.sv
// encout_pkg: shared state type, phase decode and default resolution for the ENCOUT generator
package encout_pkg;
  localparam int ENCOUT_PPR_DEF = 4096;
  typedef enum logic {IDLE, RUN} encout_st_e;
  function automatic logic [1:0] ph_to_ab(input logic [1:0] ph);
    return {ph[1] ^ ph[0], ph[1]};
  endfunction
endpackage

// File: rtl/encout_quad_step.sv
// encout_quad_step: quadrature phase, modulo-PPR position and index mark, advanced one count per step
module encout_quad_step
  import encout_pkg::*;
#(
  parameter int PPR = ENCOUT_PPR_DEF,
  localparam int W_POS = $clog2(PPR)
) (
  input  logic             i_pclk,
  input  logic             i_preset,
  input  logic             step,
  input  logic             dir,
  output logic [W_POS-1:0] o_pos,
  output logic             o_enc_a,
  output logic             o_enc_b,
  output logic             o_enc_z
);
  logic [1:0] ph, ph_nxt;
  logic [W_POS-1:0] pos_nxt;
  // dir high means reverse: phase and position count down, both wrapping naturally
  always_comb begin
    ph_nxt = dir ? ph - 2'd1 : ph + 2'd1;
    pos_nxt = dir ? o_pos - W_POS'(1) : o_pos + W_POS'(1);
  end
  // outputs decoded from the next phase so A/B/Z are registered alongside the count
  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      ph <= '0;
      o_pos <= '0;
      {o_enc_a, o_enc_b} <= 2'b00;
      o_enc_z <= 1'b0;
    end else if (step) begin
      ph <= ph_nxt;
      o_pos <= pos_nxt;
      {o_enc_a, o_enc_b} <= ph_to_ab(ph_nxt);
      o_enc_z <= pos_nxt == '0;
    end
  end
endmodule

// File: rtl/encout_ab_gen.sv
// encout_ab_gen: accepts signed step commands and paces A/B/Z quadrature output at a set period
module encout_ab_gen
  import encout_pkg::*;
#(
  parameter int W_DELTA = 16,
  parameter int W_DIV = 16,
  parameter int PPR = ENCOUT_PPR_DEF,
  localparam int W_POS = $clog2(PPR)
) (
  input  logic               i_pclk,
  input  logic               i_preset,
  input  logic               i_en,
  input  logic [W_DIV-1:0]   i_div,
  input  logic               i_cmd_valid,
  input  logic [W_DELTA-1:0] i_cmd_delta,
  output logic               o_cmd_ready,
  output logic               o_enc_a,
  output logic               o_enc_b,
  output logic               o_enc_z,
  output logic [W_POS-1:0]   o_pos,
  output logic               o_busy
);
  encout_st_e st;
  logic [W_DIV-1:0] cnt, div_r;
  logic [W_DELTA-1:0] rem;
  logic dir, accept, step;
  assign o_cmd_ready = st == IDLE;
  assign o_busy = st == RUN;
  assign accept = i_cmd_valid & o_cmd_ready;
  assign step = o_busy & i_en & (cnt == div_r - W_DIV'(1));
  // command latch, period counter and remaining-step count; a zero delta is accepted but never enters RUN
  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      st <= IDLE;
      cnt <= '0;
      rem <= '0;
      dir <= 1'b0;
      div_r <= '0;
    end else if (accept) begin
      rem <= i_cmd_delta[W_DELTA-1] ? -i_cmd_delta : i_cmd_delta;
      dir <= i_cmd_delta[W_DELTA-1];
      div_r <= i_div == '0 ? W_DIV'(1) : i_div;
      cnt <= '0;
      st <= i_cmd_delta != '0 ? RUN : IDLE;
    end else if (o_busy & i_en) begin
      cnt <= step ? '0 : cnt + W_DIV'(1);
      rem <= step ? rem - W_DELTA'(1) : rem;
      st <= step && rem == W_DELTA'(1) ? IDLE : RUN;
    end
  end
  encout_quad_step #(.PPR(PPR)) u_step (
    .i_pclk(i_pclk),
    .i_preset(i_preset),
    .step(step),
    .dir(dir),
    .o_pos(o_pos),
    .o_enc_a(o_enc_a),
    .o_enc_b(o_enc_b),
    .o_enc_z(o_enc_z)
  );
endmodule

// File: tb/tb_encout_ab_gen.sv
// tb_encout_ab_gen: command table plus corner sequences, per-step scoreboard against a quadrature model
module tb_encout_ab_gen;
  localparam int PPR = 8;
  logic i_pclk = 0, i_preset = 1, i_en = 1, i_cmd_valid = 0;
  logic [15:0] i_div = 16'd1;
  logic [15:0] i_cmd_delta = '0;
  logic o_cmd_ready, o_enc_a, o_enc_b, o_enc_z, o_busy;
  logic [2:0] o_pos;
  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 0;
  logic [2:0] prev_pos = '0, last_abz = '0;
  logic [1:0] m_ph = '0;
  logic [2:0] m_pos = '0;
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  typedef struct {int cyc; logic [2:0] pos; logic [2:0] abz;} step_t;
  typedef struct {int delta; int div; int pause; logic [2:0] pos; logic [2:0] abz;} vec_t;
  step_t q[$];
  step_t e;
  vec_t vecs [8];
  int last_step_cyc;

  encout_ab_gen #(.W_DELTA(16), .W_DIV(16), .PPR(PPR)) dut (
    .i_pclk(i_pclk),
    .i_preset(i_preset),
    .i_en(i_en),
    .i_div(i_div),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd_delta(i_cmd_delta),
    .o_cmd_ready(o_cmd_ready),
    .o_enc_a(o_enc_a),
    .o_enc_b(o_enc_b),
    .o_enc_z(o_enc_z),
    .o_pos(o_pos),
    .o_busy(o_busy)
  );

  always #5 i_pclk = ~i_pclk;
  always @(posedge i_pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // every position change must match the next expected step; between steps A/B/Z must hold
  always @(negedge i_pclk) begin
    if (mon_en) begin
      if (o_pos != prev_pos) begin
        prev_pos = o_pos;
        if (q.size() == 0) chk("unexpected_step", int'(o_pos), -1);
        else begin
          e = q.pop_front();
          chk("step_cycle", cyc, e.cyc);
          chk("step_pos", int'(o_pos), int'(e.pos));
          chk("step_abz", int'({o_enc_a, o_enc_b, o_enc_z}), int'(e.abz));
          last_abz = e.abz;
        end
      end else chk("hold_abz", int'({o_enc_a, o_enc_b, o_enc_z}), int'(last_abz));
    end
  end

  task automatic send(input int delta, input int div, input int pause);
    int k, d, n, t;
    i_cmd_valid = 1;
    i_cmd_delta = 16'(delta);
    i_div = 16'(div);
    t = 0;
    while (!o_cmd_ready && t < 2000) begin
      @(negedge i_pclk);
      t++;
    end
    if (!o_cmd_ready) chk("ready_timeout", 0, 1);
    k = cyc + 1;
    d = div == 0 ? 1 : div;
    n = delta < 0 ? -delta : delta;
    for (int i = 1; i <= n; i++) begin
      m_ph = delta < 0 ? m_ph - 2'd1 : m_ph + 2'd1;
      m_pos = delta < 0 ? m_pos - 3'd1 : m_pos + 3'd1;
      q.push_back('{k + i * d + (i > 1 ? pause : 0), m_pos, {ab_tab[m_ph], m_pos == 3'd0}});
      last_step_cyc = k + i * d;
    end
    @(negedge i_pclk);
    i_cmd_valid = 0;
    i_div = 16'd7;
    i_cmd_delta = 16'd123;
    chk("ready_after_accept", int'(o_cmd_ready), n == 0 ? 1 : 0);
    chk("busy_after_accept", int'(o_busy), n == 0 ? 0 : 1);
    if (pause > 0) begin
      while (cyc < k + d) @(negedge i_pclk);
      i_en = 0;
      repeat (pause) @(negedge i_pclk);
      i_en = 1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(negedge i_pclk);
      t++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic final_chk(input string nm, input logic [2:0] pos, input logic [2:0] abz);
    chk({nm, "_pos"}, int'(o_pos), int'(pos));
    chk({nm, "_abz"}, int'({o_enc_a, o_enc_b, o_enc_z}), int'(abz));
    chk({nm, "_ready"}, int'(o_cmd_ready), 1);
    chk({nm, "_busy"}, int'(o_busy), 0);
  endtask

  initial begin
    int k1;
    vecs = '{
      '{5, 1, 0, 3'd5, 3'b100},
      '{0, 3, 0, 3'd5, 3'b100},
      '{2, 0, 0, 3'd7, 3'b010},
      '{1, 2, 0, 3'd0, 3'b001},
      '{-1, 1, 0, 3'd7, 3'b010},
      '{3, 1, 0, 3'd2, 3'b110},
      '{-3, 4, 6, 3'd7, 3'b010},
      '{1, 1, 0, 3'd0, 3'b001}
    };
    repeat (2) @(negedge i_pclk);
    i_preset = 0;
    final_chk("reset", 3'd0, 3'b000);
    mon_en = 1;
    foreach (vecs[i]) begin
      send(vecs[i].delta, vecs[i].div, vecs[i].pause);
      drain();
      final_chk($sformatf("vec%0d", i), vecs[i].pos, vecs[i].abz);
    end
    send(9, 1, 0);
    k1 = last_step_cyc;
    send(-2, 1, 0);
    chk("b2b_accept_gap", last_step_cyc - 2, k1 + 1);
    drain();
    final_chk("b2b", 3'd7, 3'b010);
    send(5, 4, 0);
    repeat (6) @(negedge i_pclk);
    #2;
    mon_en = 0;
    i_preset = 1;
    #1;
    final_chk("async_reset", 3'd0, 3'b000);
    q.delete();
    m_ph = '0;
    m_pos = '0;
    prev_pos = '0;
    last_abz = '0;
    @(negedge i_pclk);
    i_preset = 0;
    mon_en = 1;
    send(1, 1, 0);
    drain();
    final_chk("post_reset", 3'd1, 3'b100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
